// File: rtl/matrix_scan_selector_pkg.sv
// Shared mode codes, FSM states and the row-major cell index used by the matrix selector.
// Pure declarations: no latency and no flow control.
package matrix_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    function automatic int unsigned cell_index(input int unsigned row,
                                               input int unsigned col,
                                               input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/matrix_scan_selector_if.sv
// Control-side bundle of the matrix selector: coordinate/mode inputs and registered select outputs.
// No valid/ready pair; en=0 is the only stall and it freezes the block.
interface matrix_scan_selector_if #(
    parameter int COLS = 4,
    parameter int ROWS = 4
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int SEL_W = $clog2(COLS * ROWS);

    logic             en;
    logic             mode;
    logic [COL_W-1:0] mdc;
    logic [ROW_W-1:0] mdl;
    logic [SEL_W-1:0] dmx_sel;
    logic             sel_valid;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             err;
    logic             frame_done;

    modport master (
        output en, mode, mdc, mdl,
        input  dmx_sel, sel_valid, col_idx, row_idx, err, frame_done
    );

    modport slave (
        input  en, mode, mdc, mdl,
        output dmx_sel, sel_valid, col_idx, row_idx, err, frame_done
    );

endinterface

// File: rtl/matrix_scan_selector_counter.sv
// Raster scan position: dwell counter feeding column then row wrap counters; wrap pulses on return to cell 0.
// Latency 1 cycle; en=0 holds every register and clears the wrap pulse.
module matrix_scan_counter #(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int DWELL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     restart,
    output logic [$clog2(COLS)-1:0]  col,
    output logic [$clog2(ROWS)-1:0]  row,
    output logic                     wrap
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [DW_W-1:0] dwell;
    logic            dwell_end;
    logic            col_end;
    logic            row_end;

    assign dwell_end = (dwell == DW_W'(DWELL - 1));
    assign col_end   = (col == COL_W'(COLS - 1));
    assign row_end   = (row == ROW_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            dwell <= '0;
            col   <= '0;
            row   <= '0;
            wrap  <= 1'b0;
        end else if (en) begin
            wrap <= 1'b0;
            if (dwell_end) begin
                dwell <= '0;
                if (col_end) begin
                    col <= '0;
                    if (row_end) begin
                        row  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/matrix_scan_selector.sv
// Maps (column,row) to a 1:N demux select, either by direct lookup with range check or by timed raster scan.
// Latency 1 cycle; no backpressure, en=0 freezes all state and drops sel_valid/err/frame_done.
module matrix_scan_selector
    import matrix_sel_pkg::*;
#(
    parameter int COLS  = 4,
    parameter int ROWS  = 4,
    parameter int DWELL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_scan_selector_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int SEL_W = $clog2(COLS * ROWS);
    localparam logic [COL_W:0] COL_LIM = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0] ROW_LIM = (ROW_W + 1)'(ROWS);

    state_t           state;
    state_t           state_nxt;
    logic             scan_act;
    logic             step;
    logic             restart;
    logic             col_ok;
    logic             row_ok;
    logic [COL_W-1:0] cnt_col;
    logic [ROW_W-1:0] cnt_row;
    logic             cnt_wrap;
    logic [COL_W-1:0] dir_col;
    logic [ROW_W-1:0] dir_row;
    logic [SEL_W-1:0] dir_sel;
    logic             sel_valid_q;
    logic             err_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.en) state_nxt = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
    end

    // The scan counter keeps stepping on the edge that leaves SCAN so a coincident frame wrap still pulses.
    always_comb begin
        scan_act = (state == SCAN);
        step     = bus.en && scan_act;
        restart  = bus.en && !scan_act && (bus.mode == MODE_SCAN);
    end

    generate
        if (COLS == (1 << COL_W)) begin : g_col_full
            assign col_ok = 1'b1;
        end else begin : g_col_chk
            assign col_ok = ({1'b0, bus.mdc} < COL_LIM);
        end
        if (ROWS == (1 << ROW_W)) begin : g_row_full
            assign row_ok = 1'b1;
        end else begin : g_row_chk
            assign row_ok = ({1'b0, bus.mdl} < ROW_LIM);
        end
    endgenerate

    matrix_scan_counter #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .DWELL (DWELL)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (step),
        .restart (restart),
        .col     (cnt_col),
        .row     (cnt_row),
        .wrap    (cnt_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_sel     <= '0;
            dir_col     <= '0;
            dir_row     <= '0;
            sel_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (!bus.en) begin
            sel_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (state_nxt == DIRECT) begin
            if (col_ok && row_ok) begin
                dir_sel     <= SEL_W'(cell_index(32'(bus.mdl), 32'(bus.mdc), COLS));
                dir_col     <= bus.mdc;
                dir_row     <= bus.mdl;
                sel_valid_q <= 1'b1;
                err_q       <= 1'b0;
            end else begin
                sel_valid_q <= 1'b0;
                err_q       <= 1'b1;
            end
        end else begin
            sel_valid_q <= 1'b1;
            err_q       <= 1'b0;
        end
    end

    // Both sources are registers; the state register picks which one drives the demux.
    assign bus.dmx_sel    = scan_act ? SEL_W'(cell_index(32'(cnt_row), 32'(cnt_col), COLS)) : dir_sel;
    assign bus.col_idx    = scan_act ? cnt_col : dir_col;
    assign bus.row_idx    = scan_act ? cnt_row : dir_row;
    assign bus.sel_valid  = sel_valid_q;
    assign bus.err        = err_q;
    assign bus.frame_done = cnt_wrap;

endmodule

// File: tb/tb_matrix_scan_selector.sv
// Randomised and directed bench for a 5x3, dwell-2 matrix selector against a linear-position reference model.
module tb_matrix_scan_selector;
    localparam int COLS  = 5;
    localparam int ROWS  = 3;
    localparam int DWELL = 2;
    localparam int NCELL = COLS * ROWS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_scan_selector_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    matrix_scan_selector #(.COLS(COLS), .ROWS(ROWS), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_on = 1'b0;

    // Reference: mode 0 idle / 1 direct / 2 scan, scan position as one linear cell number.
    int m_st = 0, m_pos = 0, m_tic = 0;
    int m_ds = 0, m_dc = 0, m_dr = 0;
    int m_v = 0, m_e = 0, m_f = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    endtask

    always @(posedge clk) begin : model
        int st, p, t, ds, dc, dr, v, e, f;
        st = m_st; p = m_pos; t = m_tic; ds = m_ds; dc = m_dc; dr = m_dr;
        v = m_v; e = m_e; f = m_f;
        if (rst) begin
            st = 0; p = 0; t = 0; ds = 0; dc = 0; dr = 0; v = 0; e = 0; f = 0;
        end else if (!bus.en) begin
            v = 0; e = 0; f = 0;
        end else begin
            f = 0;
            if (st == 2) begin
                t = t + 1;
                if (t == DWELL) begin
                    t = 0;
                    p = (p + 1) % NCELL;
                    f = (p == 0) ? 1 : 0;
                end
            end
            if (bus.mode) begin
                if (st != 2) begin p = 0; t = 0; end
                st = 2; v = 1; e = 0;
            end else begin
                st = 1;
                if (int'(bus.mdc) < COLS && int'(bus.mdl) < ROWS) begin
                    dc = int'(bus.mdc); dr = int'(bus.mdl); ds = dr * COLS + dc;
                    v = 1; e = 0;
                end else begin
                    v = 0; e = 1;
                end
            end
        end
        m_st <= st; m_pos <= p; m_tic <= t; m_ds <= ds; m_dc <= dc; m_dr <= dr;
        m_v <= v; m_e <= e; m_f <= f;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cmp_sel",   int'(bus.dmx_sel),   (m_st == 2) ? m_pos : m_ds);
            chk("cmp_col",   int'(bus.col_idx),   (m_st == 2) ? m_pos % COLS : m_dc);
            chk("cmp_row",   int'(bus.row_idx),   (m_st == 2) ? m_pos / COLS : m_dr);
            chk("cmp_valid", int'(bus.sel_valid), m_v);
            chk("cmp_err",   int'(bus.err),       m_e);
            chk("cmp_frame", int'(bus.frame_done), m_f);
        end
    end

    task automatic wait_sel(input int target, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(bus.dmx_sel) != target && n < budget);
        if (int'(bus.dmx_sel) != target) chk("wait_sel_timeout", int'(bus.dmx_sel), target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_tot);
        $fatal(1);
    end

    initial begin
        int scan_sel[32];
        rst = 1'b1; bus.en = 1'b0; bus.mode = 1'b0; bus.mdc = '0; bus.mdl = '0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_sel",   int'(bus.dmx_sel), 0);
        chk("rst_valid", int'(bus.sel_valid), 0);
        chk("rst_err",   int'(bus.err), 0);
        chk("rst_frame", int'(bus.frame_done), 0);

        // Direct lookups, including a rejected column and a rejected row.
        bus.en = 1'b1; bus.mode = 1'b0; bus.mdc = 3'd4; bus.mdl = 2'd2;
        @(negedge clk);
        chk("dir_sel_14", int'(bus.dmx_sel), 14);
        chk("dir_valid",  int'(bus.sel_valid), 1);
        bus.mdc = 3'd5; bus.mdl = 2'd0;
        @(negedge clk);
        chk("bad_col_sel",   int'(bus.dmx_sel), 14);
        chk("bad_col_valid", int'(bus.sel_valid), 0);
        chk("bad_col_err",   int'(bus.err), 1);
        bus.mdc = 3'd1; bus.mdl = 2'd1;
        @(negedge clk);
        chk("err_one_cycle", int'(bus.err), 0);
        chk("dir_sel_6",     int'(bus.dmx_sel), 6);
        bus.mdc = 3'd0; bus.mdl = 2'd3;
        @(negedge clk);
        chk("bad_row_err", int'(bus.err), 1);
        chk("bad_row_row", int'(bus.row_idx), 1);

        // Full frame from scan entry.
        bus.mode = 1'b1; bus.mdc = 3'd7; bus.mdl = 2'd3;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            scan_sel[k] = int'(bus.dmx_sel);
            chk("scan_frame_pulse", int'(bus.frame_done), (k == 30) ? 1 : 0);
            chk("scan_err", int'(bus.err), 0);
            if (k == 10) chk("scan_row_step5", int'(bus.row_idx), 1);
            if (k == 20) chk("scan_row_step10", int'(bus.row_idx), 2);
        end
        chk("scan_k0",  scan_sel[0], 0);
        chk("scan_k1",  scan_sel[1], 0);
        chk("scan_k2",  scan_sel[2], 1);
        chk("scan_k29", scan_sel[29], 14);
        chk("scan_k30", scan_sel[30], 0);

        // Freeze on the first dwell cycle of cell 6.
        wait_sel(6, 40);
        bus.en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("frz_sel",   int'(bus.dmx_sel), 6);
            chk("frz_valid", int'(bus.sel_valid), 0);
        end
        bus.en = 1'b1;
        @(negedge clk);
        chk("resume_sel",   int'(bus.dmx_sel), 6);
        chk("resume_valid", int'(bus.sel_valid), 1);
        @(negedge clk);
        chk("resume_next", int'(bus.dmx_sel), 7);

        // Reset in the middle of a scan.
        wait_sel(9, 40);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_sel",   int'(bus.dmx_sel), 0);
        chk("midrst_valid", int'(bus.sel_valid), 0);
        chk("midrst_col",   int'(bus.col_idx), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_sel",   int'(bus.dmx_sel), 0);
        chk("restart_valid", int'(bus.sel_valid), 1);

        // Scan -> direct -> scan.
        wait_sel(3, 40);
        bus.mode = 1'b0; bus.mdc = 3'd1; bus.mdl = 2'd1;
        @(negedge clk);
        chk("sw_dir_sel",   int'(bus.dmx_sel), 6);
        chk("sw_dir_valid", int'(bus.sel_valid), 1);
        bus.mode = 1'b1;
        @(negedge clk);
        chk("sw_scan_sel0", int'(bus.dmx_sel), 0);
        @(negedge clk);
        chk("sw_scan_dwell", int'(bus.dmx_sel), 0);
        @(negedge clk);
        chk("sw_scan_sel1", int'(bus.dmx_sel), 1);

        // Frame wrap on the same edge as a switch to direct.
        wait_sel(14, 40);
        @(negedge clk);
        bus.mode = 1'b0; bus.mdc = 3'd2; bus.mdl = 2'd1;
        @(negedge clk);
        chk("wrapsw_frame", int'(bus.frame_done), 1);
        chk("wrapsw_sel",   int'(bus.dmx_sel), 7);
        @(negedge clk);
        chk("wrapsw_frame_off", int'(bus.frame_done), 0);

        for (int i = 0; i < 800; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) bus.mode = ~bus.mode;
            bus.mdc = COL_W'($urandom_range(0, (1 << COL_W) - 1));
            bus.mdl = ROW_W'($urandom_range(0, (1 << ROW_W) - 1));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
